// File: rtl/shift_add_multiplier.sv
// Iterative unsigned 32x32->64 multiplier: one multiplier bit per cycle via shift_expander.
// Latency: 32 cycles from the operand accept edge to out_valid; initiation interval 34 cycles minimum.
// Backpressure: operands are taken only in IDLE; DONE holds product stable until out_ready is seen.
//
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - operand handshake (op_a multiplicand, op_b multiplier)
//   out_valid/out_ready  - result handshake (product = op_a*op_b)

// Partial-product stage: zero-extends the 32-bit operand to 64 bits and shifts it
// left by shift_index. Indices of 64 and above shift everything out, giving zero.
module shift_expander (
    input  logic [31:0] input_a,
    input  logic [6:0]  shift_index,
    output logic [63:0] output_b
);
    assign output_b = {32'd0, input_a} << shift_index;
endmodule

module shift_add_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [6:0]  idx_q, idx_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] partial;

    shift_expander u_shift_expander (
        .input_a     (a_q),
        .shift_index (idx_q),
        .output_b    (partial)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = 64'd0;
                    idx_d   = 7'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // idx never leaves 0..31 here, so the low five bits select the multiplier bit.
                if (b_q[idx_q[4:0]]) begin
                    acc_d = acc_q + partial;
                end
                idx_d = idx_q + 7'd1;
                // Last bit: always run the full 32 steps so latency is operand independent.
                if (idx_q == 7'd31) begin
                    idx_d   = 7'd0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            idx_q   <= 7'd0;
            acc_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    // Handshake outputs depend on state only; no combinational path from inputs.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = acc_q;

endmodule
